sa_sequencer: RTL

SA_SEQUENCER -- requirements
Module: sa_sequencer

---
 rtl/sa_sequencer_pkg.sv | 22 ++
 rtl/sa_sequencer_if.sv | 27 ++
 rtl/sa_step_counter.sv | 26 ++
 rtl/sa_sequencer.sv | 112 +++++++++++
 4 files changed

// File: rtl/sa_sequencer_pkg.sv
// Shared systolic-array constants, the sequencer state encoding and a small helper.
// Used by the sequencer, the input feeder and the PE array so that all of them agree on N, DRAIN and the count width.
package sa_sequencer_pkg;

    localparam int N_DEF     = 8;
    localparam int DRAIN_DEF = 8;
    localparam int COUNT_W   = 5;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_FEED  = 3'd2,
        S_DRAIN = 3'd3,
        S_READ  = 3'd4,
        S_DONE  = 3'd5
    } seq_state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sa_sequencer_if.sv
// Control bundle between the sequencer (master), the feeder/PE array and the result consumer (slave).
// The consumer applies back-pressure on readout through out_ready.
interface sa_sequencer_if
    import sa_sequencer_pkg::*;
#(
    parameter int N = N_DEF
);
    logic                 start;
    logic                 out_ready;
    logic [COUNT_W-1:0]   count;
    logic                 pe_clear;
    logic                 pe_en;
    logic [$clog2(N)-1:0] row_sel;
    logic                 out_valid;
    logic                 busy;
    logic                 done;

    modport master (
        input  start, out_ready,
        output count, pe_clear, pe_en, row_sel, out_valid, busy, done
    );

    modport slave (
        output start, out_ready,
        input  count, pe_clear, pe_en, row_sel, out_valid, busy, done
    );
endinterface

// File: rtl/sa_step_counter.sv
// Loadable up-counter with a combinational terminal-count flag (value == term).
// Load wins over increment; one cycle from load/increment to the new value.
module sa_step_counter #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] load_val,
    input  logic [W-1:0] term,
    output logic [W-1:0] value,
    output logic         tc
);
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            value <= '0;
        end else if (load) begin
            value <= load_val;
        end else if (en) begin
            value <= value + W'(1);
        end
    end

    assign tc = (value == term);
endmodule

// File: rtl/sa_sequencer.sv
// Systolic-array sequencer: CLEAR, FEED (2N-1), DRAIN, row readout, DONE; all outputs registered, one-cycle start latency.
// Readout stalls indefinitely while out_ready is low; start is ignored unless IDLE.
module sa_sequencer
    import sa_sequencer_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int DRAIN = DRAIN_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    sa_sequencer_if.master  bus
);
    localparam int RS_W   = $clog2(N);
    localparam int STEP_W = $clog2(max_int(2 * N - 1, DRAIN) + 1);

    localparam logic [RS_W-1:0]   LAST_ROW  = RS_W'(N - 1);
    localparam logic [STEP_W-1:0] FEED_TC   = STEP_W'(2 * N - 2);
    localparam logic [STEP_W-1:0] DRAIN_TC  = STEP_W'(DRAIN - 1);

    seq_state_t          state;
    logic [STEP_W-1:0]   step;
    logic [STEP_W-1:0]   step_term;
    logic                step_tc;
    logic                step_load;

    // Counter restarts from zero whenever it is not timing FEED/DRAIN, and on their last cycle.
    assign step_load = !(state inside {S_FEED, S_DRAIN}) || step_tc;

    always_comb begin
        step_term = FEED_TC;
        if (state == S_DRAIN) begin
            step_term = DRAIN_TC;
        end
    end

    sa_step_counter #(.W(STEP_W)) u_step (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (step_load),
        .en       (1'b1),
        .load_val ('0),
        .term     (step_term),
        .value    (step),
        .tc       (step_tc)
    );

    // Outputs are loaded with the values of the state being entered.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            bus.count     <= '0;
            bus.pe_clear  <= 1'b0;
            bus.pe_en     <= 1'b0;
            bus.row_sel   <= '0;
            bus.out_valid <= 1'b0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        state        <= S_CLEAR;
                        bus.pe_clear <= 1'b1;
                        bus.busy     <= 1'b1;
                    end
                end
                S_CLEAR: begin
                    state        <= S_FEED;
                    bus.pe_clear <= 1'b0;
                    bus.pe_en    <= 1'b1;
                    bus.count    <= COUNT_W'(1);
                end
                S_FEED: begin
                    if (step_tc) begin
                        state     <= S_DRAIN;
                        bus.count <= '0;
                    end else begin
                        bus.count <= bus.count + COUNT_W'(1);
                    end
                end
                S_DRAIN: begin
                    if (step_tc) begin
                        state         <= S_READ;
                        bus.pe_en     <= 1'b0;
                        bus.out_valid <= 1'b1;
                        bus.row_sel   <= '0;
                    end
                end
                S_READ: begin
                    if (bus.out_ready) begin
                        if (bus.row_sel == LAST_ROW) begin
                            state         <= S_DONE;
                            bus.out_valid <= 1'b0;
                            bus.done      <= 1'b1;
                        end else begin
                            bus.row_sel <= bus.row_sel + RS_W'(1);
                        end
                    end
                end
                S_DONE: begin
                    state       <= S_IDLE;
                    bus.done    <= 1'b0;
                    bus.busy    <= 1'b0;
                    bus.row_sel <= '0;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule
